serial_transmitter: RTL and testbench
=====================================

Name: serial_transmitter

Overview:
Parallel-to-serial framing stage that sits directly upstream of the serial receiver and drives its `in` line. It accepts a byte over a valid/ready handshake and emits one frame: start bit 0, DATA_WIDTH data bits LSB first, one parity bit, stop bit 1. The parity bit is what the downstream decoder checks to raise `err`. It closes the loopback path for transceiver-level testing.

Parameters:
DATA_WIDTH, 8, payload bits per frame; must equal the receiver/decoder DATA_WIDTH.
CLKS_PER_BIT, 1, clock cycles each serial bit is held; legal values are ≥1.
PARITY_ODD, 1, 1 = odd parity (data + parity has an odd count of ones); 0 = even parity.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
arst  input  1  asynchronous reset, active-low; asserts immediately, releases synchronously to clk.
data_in  input  DATA_WIDTH  byte to transmit; sampled only on an accepted handshake.
valid  input  1  data_in is valid.
ready  output  1  transmitter can accept data this cycle.
out  output  1  serial line; idles high.
busy  output  1  a frame is in progress (any state other than IDLE).
done  output  1  one-cycle pulse marking the end of a frame.

Behaviour:
- Reset (arst=0): state=IDLE, out=1, ready=1, busy=0, done=0, shift register=0, bit counter=0, tick counter=0.
- Handshake: the transfer occurs on a clock edge with valid && ready. data_in is latched into the shift register and the parity bit is computed and latched at that edge.
  - Parity = ~^data_in when PARITY_ODD=1.
  - Parity = ^data_in when PARITY_ODD=0.
- ready is combinational:
  - high in IDLE;
  - high in the final cycle of STOP;
  - low in every other cycle.
  - This allows back-to-back frames with no idle gap.
- valid while ready=0 is ignored; data_in is not sampled. Changes to data_in after acceptance do not affect the frame in flight.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: out=1. On accept, go to START.
  - START: out=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: out=shift_reg[0] for CLKS_PER_BIT cycles per bit, then shift right. The bit counter runs 0..DATA_WIDTH-1. After the last bit, go to PARITY.
  - PARITY: out=latched parity for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: out=1 for CLKS_PER_BIT cycles. On the final cycle, done=1. Then go to START if an accept occurs on that edge, otherwise go to IDLE.
- out is driven from a register (no glitches).
- Latency with acceptance at edge T and CLKS_PER_BIT=1:
  - start bit on cycle T+1;
  - data bit i on cycle T+2+i;
  - parity on cycle T+DATA_WIDTH+2;
  - stop bit and done on cycle T+DATA_WIDTH+3.
- Frame length is (DATA_WIDTH+3)*CLKS_PER_BIT cycles.
- The tick counter is $clog2(CLKS_PER_BIT) bits wide (minimum 1). It wraps to 0 at CLKS_PER_BIT-1, and that wrap advances the bit or state. With CLKS_PER_BIT=1 it is effectively unused.
- The bit counter is $clog2(DATA_WIDTH) bits wide (minimum 1). It resets to 0 on every entry to DATA.
- Reset mid-frame: the frame is aborted immediately, out returns to 1, and outputs take their reset values. No done pulse is issued. The partial frame must not resemble a valid frame to the receiver beyond the point of truncation.
- done never coincides with ready=0. A new frame cannot start in the same cycle as done except through the STOP→START accept path.

Test Plan:
- Reset, then valid=0 for 20 cycles → out=1, ready=1, busy=0, done=0 throughout.
- data_in=0xA5, valid pulse, defaults → out sequence:
  - 0 (start)
  - 1,0,1,0,0,1,0,1 (data, LSB first)
  - 1 (odd parity; 0xA5 has 4 ones)
  - 1 (stop)
  - done high on the stop cycle; ready low for 10 cycles after accept.
- data_in=0x01 then 0xFF, valid held high continuously:
  - frame 1 parity = 0;
  - frame 2 START immediately follows the frame-1 stop cycle, with no idle gap;
  - frame 2 parity = 1;
  - exactly 2 done pulses, 11 cycles apart.
- CLKS_PER_BIT=4, data_in=0x3C → each bit is held 4 cycles, the frame lasts 44 cycles, and parity=1.
- Loopback into the receiver and decoder, sending 0x00, 0x7E, 0x80:
  - receiver done pulses once per frame;
  - decoder out_byte matches each sent byte;
  - err=0 for all three.
- arst asserted during data bit 3 of 0x55 → out=1 and busy=0 immediately. After release, a fresh frame for 0xAA transmits correctly, with no done pulse for the aborted frame.

Source files
------------

// File: rtl/serial_transmitter_if.sv
// Handshake and serial-line bundle for serial_transmitter.
// The producer side uses master; the transmitter uses slave.
interface serial_transmitter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid;
  logic                  ready;
  logic                  out;
  logic                  busy;
  logic                  done;

  modport master (
    output data_in,
    output valid,
    input  ready,
    input  out,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  valid,
    output ready,
    output out,
    output busy,
    output done
  );
endinterface

// File: rtl/serial_transmitter.sv
// Parallel-to-serial framer: start bit 0, DATA_WIDTH data bits LSB first,
// parity bit, stop bit 1. Back-to-back frames are accepted on the last stop cycle.
module serial_transmitter #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_ODD   = 1
) (
  input  logic                 clk,
  input  logic                 arst,
  serial_transmitter_if.slave  bus
);
  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BIT_W-1:0]      r_bit;
  logic [TICK_W-1:0]     r_tick;
  logic                  r_parity;
  logic                  r_out;

  logic                  w_last_tick;
  logic                  w_ready;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_shift_next;

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d);
    return (PARITY_ODD != 0) ? ~^d : ^d;
  endfunction

  assign w_last_tick  = (r_tick == TICK_LAST);
  // Ready on the last stop cycle lets the next frame start with no idle gap.
  assign w_ready      = (r_state == IDLE) || ((r_state == STOP) && w_last_tick);
  assign w_accept     = bus.valid && w_ready;
  assign w_shift_next = r_shift >> 1;

  assign bus.ready = w_ready;
  assign bus.out   = r_out;
  assign bus.busy  = (r_state != IDLE);
  assign bus.done  = (r_state == STOP) && w_last_tick;

  // Frame sequencer: state, bit/tick counters, shift register and the registered line.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bit    <= '0;
      r_tick   <= '0;
      r_parity <= 1'b0;
      r_out    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_tick <= '0;
          if (w_accept) begin
            r_shift  <= bus.data_in;
            r_parity <= calc_parity(bus.data_in);
            r_out    <= 1'b0;
            r_state  <= START;
          end else begin
            r_out <= 1'b1;
          end
        end
        START: begin
          if (w_last_tick) begin
            r_tick  <= '0;
            r_bit   <= '0;
            r_out   <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        DATA: begin
          if (w_last_tick) begin
            r_tick <= '0;
            if (r_bit == BIT_LAST) begin
              r_out   <= r_parity;
              r_state <= PARITY;
            end else begin
              r_bit   <= r_bit + BIT_W'(1);
              r_shift <= w_shift_next;
              r_out   <= w_shift_next[0];
            end
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        PARITY: begin
          if (w_last_tick) begin
            r_tick  <= '0;
            r_out   <= 1'b1;
            r_state <= STOP;
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        STOP: begin
          if (w_last_tick) begin
            r_tick <= '0;
            if (w_accept) begin
              r_shift  <= bus.data_in;
              r_parity <= calc_parity(bus.data_in);
              r_out    <= 1'b0;
              r_state  <= START;
            end else begin
              r_out   <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        default: begin
          r_tick  <= '0;
          r_out   <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_transmitter.sv
// Self-checking bench: per-cycle scoreboard of {out, done, ready, busy} for a
// CLKS_PER_BIT=1 and a CLKS_PER_BIT=4 instance, plus a simple frame receiver.
module tb_serial_transmitter;
  logic clk = 1'b0;
  logic arst;

  always #5 clk = ~clk;

  serial_transmitter_if #(.DATA_WIDTH(8)) b1 ();
  serial_transmitter_if #(.DATA_WIDTH(8)) b4 ();

  serial_transmitter #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_ODD(1)) dut1 (
    .clk (clk),
    .arst(arst),
    .bus (b1)
  );

  serial_transmitter #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_ODD(1)) dut4 (
    .clk (clk),
    .arst(arst),
    .bus (b4)
  );

  typedef struct packed {
    logic out;
    logic done;
    logic ready;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         busy4 = 0;
  int         rx_frames = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte;
  logic       rx_par;
  logic       par1;
  logic       par4;
  exp_t       sb1[$];
  exp_t       sb4[$];
  logic [7:0] rx_exp[$];
  int         done_cyc[$];
  vec_t       tbl[6];

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic frame_bit(input int k, input logic [7:0] d, input logic p);
    if (k == 0) return 1'b0;
    else if (k <= 8) return d[k-1];
    else if (k == 9) return p;
    else return 1'b1;
  endfunction

  always @(posedge clk) cyc++;

  // Expected per-cycle line behaviour is queued at the accepting edge.
  always @(posedge clk) begin
    if (arst && b1.valid && b1.ready) begin
      for (int k = 0; k < 11; k++)
        sb1.push_back('{out: frame_bit(k, b1.data_in, par1), done: (k == 10), ready: (k == 10)});
      rx_exp.push_back(b1.data_in);
    end
    if (arst && b4.valid && b4.ready) begin
      for (int k = 0; k < 11; k++)
        for (int t = 0; t < 4; t++)
          sb4.push_back('{out: frame_bit(k, b4.data_in, par4),
                          done: (k == 10 && t == 3), ready: (k == 10 && t == 3)});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      chk("dut1 frame", {12'd0, b1.out, b1.done, b1.ready, b1.busy}, {12'd0, e.out, e.done, e.ready, 1'b1});
    end else begin
      chk("dut1 idle", {12'd0, b1.out, b1.done, b1.ready, b1.busy}, 16'h000a);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b4.busy) busy4++;
    if (sb4.size() > 0) begin
      e = sb4.pop_front();
      chk("dut4 frame", {12'd0, b4.out, b4.done, b4.ready, b4.busy}, {12'd0, e.out, e.done, e.ready, 1'b1});
    end else begin
      chk("dut4 idle", {12'd0, b4.out, b4.done, b4.ready, b4.busy}, 16'h000a);
    end
  end

  always @(negedge clk) begin
    if (b1.done) done_cyc.push_back(cyc);
  end

  // Receiver model on dut1's line: decodes each frame and checks odd parity.
  always @(negedge clk) begin
    if (rx_cnt == 0) begin
      if (arst && b1.out == 1'b0) begin
        rx_cnt  = 1;
        rx_byte = 8'h00;
      end
    end else if (rx_cnt <= 8) begin
      rx_byte[rx_cnt-1] = b1.out;
      rx_cnt++;
    end else if (rx_cnt == 9) begin
      rx_par = b1.out;
      rx_cnt++;
    end else begin
      rx_cnt = 0;
      rx_frames++;
      chk("rx stop bit", {15'd0, b1.out}, 16'd1);
      chk("rx odd parity", {15'd0, ^{rx_byte, rx_par}}, 16'd1);
      if (rx_exp.size() > 0) begin
        chk("rx byte", {8'd0, rx_byte}, {8'd0, rx_exp.pop_front()});
      end else begin
        total++;
        bad++;
        $display("FAIL rx byte: decoded %h with nothing sent", rx_byte);
      end
    end
  end

  task automatic send(input int which, input logic [7:0] d, input logic p, input bit hold);
    int n = 0;
    if (which == 1) begin
      b1.data_in = d; b1.valid = 1'b1; par1 = p;
    end else begin
      b4.data_in = d; b4.valid = 1'b1; par4 = p;
    end
    while (!((which == 1) ? b1.ready : b4.ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL send%0d: ready never rose for %h", which, d);
    end
    @(negedge clk);
    if (!hold) begin
      if (which == 1) b1.valid = 1'b0;
      else b4.valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int which);
    int n = 0;
    while (((which == 1) ? (sb1.size() != 0 || b1.busy) : (sb4.size() != 0 || b4.busy)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL wait_idle%0d: still busy after %0d cycles", which, n);
    end
  endtask

  initial begin
    arst = 1'b0;
    b1.valid = 1'b0; b1.data_in = 8'h00; par1 = 1'b0;
    b4.valid = 1'b0; b4.data_in = 8'h00; par4 = 1'b0;
    repeat (3) @(negedge clk);
    arst = 1'b1;
    repeat (20) @(negedge clk);

    tbl[0] = '{8'hA5, 1'b1};
    tbl[1] = '{8'h00, 1'b1};
    tbl[2] = '{8'h7E, 1'b1};
    tbl[3] = '{8'h80, 1'b0};
    tbl[4] = '{8'h3C, 1'b1};
    tbl[5] = '{8'h01, 1'b0};
    for (int i = 0; i < 6; i++) begin
      send(1, tbl[i].data, tbl[i].par, 1'b0);
      wait_idle(1);
      repeat (2) @(negedge clk);
    end

    // Back-to-back frames with valid held high throughout.
    done_cyc.delete();
    send(1, 8'h01, 1'b0, 1'b1);
    send(1, 8'hFF, 1'b1, 1'b0);
    wait_idle(1);
    chk("b2b done count", 16'(done_cyc.size()), 16'd2);
    if (done_cyc.size() == 2)
      chk("b2b done spacing", 16'(done_cyc[1] - done_cyc[0]), 16'd11);

    // Four clocks per bit.
    busy4 = 0;
    send(4, 8'h3C, 1'b1, 1'b0);
    wait_idle(4);
    chk("cpb4 frame length", 16'(busy4), 16'd44);

    // Abort during data bit 3, then a clean frame.
    done_cyc.delete();
    send(1, 8'h55, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    #1 arst = 1'b0;
    sb1.delete();
    rx_exp.delete();
    rx_cnt = 0;
    #1 chk("abort immediate", {12'd0, b1.out, b1.done, b1.ready, b1.busy}, 16'h000a);
    @(negedge clk);
    arst = 1'b1;
    send(1, 8'hAA, 1'b1, 1'b0);
    wait_idle(1);
    chk("abort done count", 16'(done_cyc.size()), 16'd1);
    chk("rx frame count", 16'(rx_frames), 16'd9);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
